// File: rtl/menu_cmd_sched_if.sv
// Command handshake between the button scheduler (master) and the menu FSM (slave).
// cmd_code: 0=AD, 1=AT, 2=SEL, 3=CLC; meaningful only while cmd_valid is high.
interface menu_cmd_sched_if;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_code, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/menu_cmd_sched.sv
// menu_cmd_sched: synchronizes and debounces the four board buttons (AD, AT, SEL, CLC),
// turns each press into a pending request and issues requests one at a time to the
// menu FSM by fixed priority (CLC > SEL > AT > AD) over a valid/ready handshake.
// Optional feature macro: MENU_CMD_REPEAT_EN -- when defined, a held AD or AT button
// produces a synthetic press every REPEAT_CYCLES cycles after the real press.
// The reset input is active-low and asynchronous despite its name.
module menu_cmd_sched #(
    parameter int DB_CNT_W      = 18,
    parameter int REPEAT_CYCLES = 4000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_ad,
    input  logic               btn_at,
    input  logic               btn_sel,
    input  logic               btn_clc,
    menu_cmd_sched_if.master   cmd,
    output logic [3:0]         pending,
    output logic [3:0]         drop_cnt
);

    typedef enum logic {
        ST_IDLE,
        ST_OFFER
    } state_t;

    logic [3:0] btn_raw;
    logic [3:0] evt;          // press events (real or synthetic), one cycle each

    assign btn_raw = {btn_clc, btn_sel, btn_at, btn_ad};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic                sync1_q;
            logic                sync2_q;
            logic                stable_q;
            logic                stable_d;
            logic                stable_prev_q;
            logic [DB_CNT_W-1:0] db_cnt_q;
            logic [DB_CNT_W-1:0] db_cnt_d;
            logic                press;
            logic                rpt_hit;

            // Two-flop synchronizer for the asynchronous button level
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                end
            end

            // Debounce: accept a new level only after it has differed for a full counter span
            always_comb begin
                db_cnt_d = db_cnt_q;
                stable_d = stable_q;
                if (sync2_q == stable_q) begin
                    db_cnt_d = '0;
                end else if (db_cnt_q == {DB_CNT_W{1'b1}}) begin
                    stable_d = sync2_q;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end

            // Debounce state and previous stable level for edge detection
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    db_cnt_q      <= '0;
                    stable_q      <= 1'b0;
                    stable_prev_q <= 1'b0;
                end else begin
                    db_cnt_q      <= db_cnt_d;
                    stable_q      <= stable_d;
                    stable_prev_q <= stable_q;
                end
            end

            // Only rising edges of the debounced level count as presses
            assign press = stable_q & ~stable_prev_q;

`ifdef MENU_CMD_REPEAT_EN
            if (gi < 2) begin : g_rpt
                localparam int RPT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
                localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

                logic [RPT_W-1:0] rpt_cnt_q;
                logic [RPT_W-1:0] rpt_cnt_d;
                logic             rpt_fire;

                // Held-button timer: restarts at the real press, fires every REPEAT_CYCLES
                always_comb begin
                    rpt_cnt_d = rpt_cnt_q;
                    rpt_fire  = 1'b0;
                    if (!stable_q || press) begin
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == RPT_LAST) begin
                        rpt_cnt_d = '0;
                        rpt_fire  = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end

                // Held-button timer register
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        rpt_cnt_q <= '0;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_d;
                    end
                end

                assign rpt_hit = rpt_fire;
            end else begin : g_no_rpt
                assign rpt_hit = 1'b0;
            end
`else
            assign rpt_hit = 1'b0;
`endif

            assign evt[gi] = press | rpt_hit;
        end
    endgenerate

    state_t     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] drop_q, drop_d;
    logic [3:0] clr;
    logic [3:0] lost;
    logic [4:0] drop_sum;

    // Arbiter FSM plus pending/drop bookkeeping
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        clr      = 4'b0000;
        drop_sum = {1'b0, drop_q};
        drop_d   = drop_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != 4'b0000) begin
                    state_d = ST_OFFER;
                    if (pending_q[3])      code_d = 2'd3;
                    else if (pending_q[2]) code_d = 2'd2;
                    else if (pending_q[1]) code_d = 2'd1;
                    else                   code_d = 2'd0;
                end
            end
            ST_OFFER: begin
                // code_q is frozen here; new presses only update pending
                if (cmd.cmd_ready) begin
                    clr     = 4'b0001 << code_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A press on a bit being cleared this cycle re-queues instead of dropping
        lost      = evt & pending_q & ~clr;
        pending_d = (pending_q & ~clr) | evt;
        for (int i = 0; i < 4; i++) begin
            drop_sum = drop_sum + {4'b0000, lost[i]};
        end
        drop_d = (drop_sum > 5'd15) ? 4'hF : drop_sum[3:0];
    end

    // Arbiter and request state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            code_q    <= 2'd0;
            pending_q <= 4'b0000;
            drop_q    <= 4'h0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    // Valid comes straight from the state flop so reset drops it immediately
    assign cmd.cmd_valid = (state_q == ST_OFFER);
    assign cmd.cmd_code  = code_q;
    assign pending       = pending_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_menu_cmd_sched.sv
// Scoreboard bench for menu_cmd_sched: stimulus pushes expected command codes,
// a monitor pops and compares on every accepted handshake.
module tb_menu_cmd_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_ad = 1'b0;
    logic       btn_at = 1'b0;
    logic       btn_sel = 1'b0;
    logic       btn_clc = 1'b0;
    logic [3:0] pending;
    logic [3:0] drop_cnt;

    menu_cmd_sched_if cmd_if ();

    menu_cmd_sched #(
        .DB_CNT_W      (4),
        .REPEAT_CYCLES (40)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_ad   (btn_ad),
        .btn_at   (btn_at),
        .btn_sel  (btn_sel),
        .btn_clc  (btn_clc),
        .cmd      (cmd_if),
        .pending  (pending),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_q[$];
    int hs_cyc[$];
    int hs_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every accepted command and checks cmd_code stays put while stalled
    initial begin
        logic       pv;
        logic [1:0] pc;
        int         e;
        pv = 1'b0;
        pc = 2'd0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pv = 1'b0;
            end else if (cmd_if.cmd_valid) begin
                if (pv) check("code_hold", cmd_if.cmd_code, pc);
                if (cmd_if.cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_cmd: got code %0d, expected no command (cycle %0d)",
                                 cmd_if.cmd_code, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("cmd_code", cmd_if.cmd_code, e);
                    end
                    hs_cnt++;
                    hs_cyc.push_back(cyc);
                    pv = 1'b0;
                end else begin
                    pv = 1'b1;
                    pc = cmd_if.cmd_code;
                end
            end else begin
                pv = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n_exp;
        int n;

        cmd_if.cmd_ready = 1'b0;
        tick(3);
        // reset state
        check("rst_valid", cmd_if.cmd_valid, 0);
        check("rst_code", cmd_if.cmd_code, 0);
        check("rst_pending", pending, 0);
        check("rst_drop", drop_cnt, 0);
        reset = 1'b1;
        tick(2);
        check("post_rst_valid", cmd_if.cmd_valid, 0);

        // 1: clean AD press held 40 cycles
        cmd_if.cmd_ready = 1'b1;
        base = hs_cnt;
        exp_q.push_back(0);
        btn_ad = 1'b1;
        tick(40);
        btn_ad = 1'b0;
        tick(30);
        check("t1_cmds", hs_cnt - base, 1);
        check("t1_pending", pending, 0);
        check("t1_drop", drop_cnt, 0);

        // 2: bouncing AD never settles
        base = hs_cnt;
        for (int i = 0; i < 10; i++) begin
            btn_ad = ~btn_ad;
            tick(3);
        end
        btn_ad = 1'b0;
        tick(30);
        check("t2_cmds", hs_cnt - base, 0);
        check("t2_pending", pending, 0);

        // 3: AD, AT, CLC together -> 3, 1, 0 two cycles apart
        base = hs_cnt;
        exp_q.push_back(3);
        exp_q.push_back(1);
        exp_q.push_back(0);
        btn_ad = 1'b1;
        btn_at = 1'b1;
        btn_clc = 1'b1;
        tick(30);
        btn_ad = 1'b0;
        btn_at = 1'b0;
        btn_clc = 1'b0;
        tick(30);
        check("t3_cmds", hs_cnt - base, 3);
        if (hs_cnt - base == 3) begin
            check("t3_gap1", hs_cyc[base + 1] - hs_cyc[base], 2);
            check("t3_gap2", hs_cyc[base + 2] - hs_cyc[base + 1], 2);
        end

        // 4: SEL pressed 3 times while stalled -> one pending, two drops
        cmd_if.cmd_ready = 1'b0;
        base = hs_cnt;
        for (int i = 0; i < 3; i++) begin
            btn_sel = 1'b1;
            tick(30);
            btn_sel = 1'b0;
            tick(30);
        end
        check("t4_pending", pending, 4);
        check("t4_drop", drop_cnt, 2);
        check("t4_valid", cmd_if.cmd_valid, 1);
        check("t4_code", cmd_if.cmd_code, 2);
        exp_q.push_back(2);
        cmd_if.cmd_ready = 1'b1;
        tick(5);
        cmd_if.cmd_ready = 1'b0;
        check("t4_cmds", hs_cnt - base, 1);
        check("t4_pending_after", pending, 0);

        // 5: reset during a CLC offer
        btn_clc = 1'b1;
        n = 0;
        while (!cmd_if.cmd_valid && n < 60) begin
            tick(1);
            n++;
        end
        check("t5_valid", cmd_if.cmd_valid, 1);
        check("t5_code", cmd_if.cmd_code, 3);
        #2;
        reset = 1'b0;
        #1;
        check("t5_async_valid", cmd_if.cmd_valid, 0);
        btn_clc = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);
        check("t5_pending", pending, 0);
        check("t5_drop", drop_cnt, 0);
        tick(30);
        check("t5_quiet", cmd_if.cmd_valid, 0);

        // 6: AT held ~130 cycles past debounce
        cmd_if.cmd_ready = 1'b1;
        base = hs_cnt;
`ifdef MENU_CMD_REPEAT_EN
        n_exp = 4;
`else
        n_exp = 1;
`endif
        for (int i = 0; i < n_exp; i++) exp_q.push_back(1);
        btn_at = 1'b1;
        tick(148);
        btn_at = 1'b0;
        tick(40);
        check("t6_cmds", hs_cnt - base, n_exp);
        check("t6_pending", pending, 0);
        check("t6_drop", drop_cnt, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/menu_cmd_sched.md
# menu_cmd_sched

Input conditioner and command scheduler placed between the four board push-buttons (AD, AT, SEL, CLC) and the `menu_comida` state machine. It synchronizes and debounces each button and turns each press into a one-shot pending request. Simultaneous or back-to-back presses are arbitrated by fixed priority and issued one at a time to the menu FSM over a valid/ready handshake. This replaces the raw pin wiring and the divided ripple clock with a single-clock, lossless command stream.

## Interface
- `DB_CNT_W`, 18: debounce counter width; a level must be stable for 2^DB_CNT_W cycles (16.4 ms at 16 MHz).
- `REPEAT_CYCLES`, 4000000: auto-repeat period in cycles; used only when `MENU_CMD_REPEAT_EN` is defined.
- `clk` in 1: single system clock (board 16 MHz); all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset; assertion clears all state immediately, release is synchronous to `clk`.
- `btn_ad`, `btn_at`, `btn_sel`, `btn_clc` in 1 each: raw button levels, active-high, asynchronous to `clk`.
- `cmd_valid` out 1: a command is offered.
- `cmd_code` out 2: 0=AD, 1=AT, 2=SEL, 3=CLC; valid only while `cmd_valid`=1.
- `cmd_ready` in 1: the menu FSM accepts the offered command.
- `pending` out 4: per-button pending flags, bit0=AD … bit3=CLC.
- `drop_cnt` out 4: saturating count of presses lost because the button was already pending.

## Operation
- Per button: 2-flop synchronizer, then debouncer. The counter clears whenever the synchronized level equals the stable level. Otherwise it increments, and when it reaches 2^DB_CNT_W−1 the stable level takes the new value and the counter clears.
- A rising edge of the stable level is a press event (1-cycle). Falling edges are ignored.
- Press event with the pending bit clear: the bit is set next cycle. Press event with the bit already set: `drop_cnt` increments and saturates at 15.
- Arbiter FSM with states IDLE and OFFER:
  - IDLE: if `pending`≠0, latch the highest-priority bit (CLC > SEL > AT > AD) into `cmd_code` and go to OFFER. Otherwise stay in IDLE.
  - OFFER: `cmd_valid`=1, and `cmd_code` holds stable until the handshake. On `cmd_ready`=1, clear that pending bit and go to IDLE.
- A press arriving during OFFER never changes `cmd_code`. Higher-priority requests wait for the next IDLE.
- Same-cycle handshake clear and press event on the same bit: the bit stays set (new press queued) and is not counted as a drop.
- Reset values: `cmd_valid`=0, `cmd_code`=0, `pending`=0, `drop_cnt`=0, stable levels=0, counters=0, FSM=IDLE.
- Reset mid-offer: `cmd_valid` drops asynchronously and all pending requests are discarded.

## Timing
- The stable level changes 2 (sync) + 2^DB_CNT_W cycles after the raw level settles.
- Press event at cycle N: `pending` bit set at N+1, `cmd_valid` high at N+2 if the FSM is in IDLE.
- Handshake at cycle M: `cmd_valid`=0 at M+1 (IDLE), next offer no earlier than M+2. At most one command per 2 cycles.
- `cmd_ready` asserted while `cmd_valid`=0 is ignored.
- `drop_cnt` updates 1 cycle after the dropping press event.

## Configuration
- `MENU_CMD_REPEAT_EN` defined: while stable AD or AT stays high, a synthetic press event is generated every REPEAT_CYCLES cycles after the real press. A held-button counter of ceil(log2(REPEAT_CYCLES)) bits is used. SEL and CLC never repeat. Synthetic events follow the same pending/drop rules.
- Not defined: no repeat logic is synthesized, and one physical press yields exactly one event.

## Test plan
Bench uses DB_CNT_W=4 and REPEAT_CYCLES=40.
- Clean AD press held 40 cycles, `cmd_ready`=1 → exactly one command with `cmd_code`=0 and one `cmd_valid` pulse. `pending` returns to 0 and `drop_cnt`=0.
- AD raw toggling every 3 cycles for 30 cycles, then low → no press event and `cmd_valid` never asserted.
- AD, AT and CLC pressed in the same cycle, `cmd_ready`=1 → codes issued in the order 3, 1, 0, two cycles apart.
- `cmd_ready`=0, SEL pressed 3 times → one pending SEL and `drop_cnt`=2. `cmd_code`=2 is held stable until `cmd_ready` rises.
- `reset` pulsed low during OFFER with CLC pending → `cmd_valid`=0 within the same cycle; `pending`=0 and `drop_cnt`=0 after release.
- `MENU_CMD_REPEAT_EN` defined, AT held 130 cycles past debounce, `cmd_ready`=1 → 4 commands with code 1. The same stimulus with the macro undefined → 1 command.
